id_ex_stage: RTL and testbench

- ID/EX pipeline register directly downstream of the opcode controller. Captures its control outputs (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp) together with decoded operands, and presents them to EX.
- Contains load-use hazard detection: stalls IF/ID and inserts a bubble.
- Honors a downstream hold and a pipeline flush.
- Keeps a saturating count of inserted bubbles for performance analysis.

---
 rtl/id_ex_stage_pkg.sv | 25 ++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants and the control bundle carried from the opcode
// controller through ID/EX.
package id_ex_stage_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   typedef struct packed {
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction currently in ID.
module id_ex_stage_hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             ex_valid,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_valid,
   input  logic             id_alusrc,
   input  logic             id_memwrite,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   output logic             hazard
);

   logic uses_rs2;

   // rs2 is read by R-type (register operand) and by stores (store data)
   assign uses_rs2 = !id_alusrc | id_memwrite;

   assign hazard = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                   ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, downstream hold,
// flush and a saturating bubble counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_alusrc,
   input  logic              id_memtoreg,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic [1:0]        id_aluop,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              ex_hold,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_alusrc,
   output logic              ex_memtoreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic [1:0]        ex_aluop,
   output logic [DATA_W-1:0] ex_rs1_data,
   output logic [DATA_W-1:0] ex_rs2_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_W-1:0]  ex_rs1,
   output logic [REG_W-1:0]  ex_rs2,
   output logic [REG_W-1:0]  ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic              stall_id,
   output logic [CNT_W-1:0]  bubble_count
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  hazard;

   assign id_ctrl = '{alusrc:   id_alusrc,
                      memtoreg: id_memtoreg,
                      regwrite: id_regwrite,
                      memread:  id_memread,
                      memwrite: id_memwrite,
                      aluop:    id_aluop};

   id_ex_stage_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .ex_valid    (ex_valid),
      .ex_memread  (ex_ctrl.memread),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_alusrc   (id_alusrc),
      .id_memwrite (id_memwrite),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .hazard      (hazard)
   );

   assign stall_id = hazard | ex_hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_ctrl      <= CTRL_NOP;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_funct3    <= '0;
         ex_funct7    <= '0;
         bubble_count <= '0;
      end else if (flush) begin
         // kill only the controls; stale operands are harmless once invalid
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_NOP;
      end else if (!ex_hold) begin
         if (hazard) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            if (bubble_count != '1)
               bubble_count <= bubble_count + CNT_W'(1);
         end else begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7   <= id_funct7;
         end
      end
   end

   assign ex_alusrc   = ex_ctrl.alusrc;
   assign ex_memtoreg = ex_ctrl.memtoreg;
   assign ex_regwrite = ex_ctrl.regwrite;
   assign ex_memread  = ex_ctrl.memread;
   assign ex_memwrite = ex_ctrl.memwrite;
   assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/hold/flush scenarios followed by
// random traffic, all scored against a cycle-level reference model.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite;
   logic [1:0]        id_aluop;
   logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
   logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]        id_funct3;
   logic [6:0]        id_funct7;
   logic              ex_hold, flush;
   logic              ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
   logic [1:0]        ex_aluop;
   logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
   logic [REG_W-1:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]        ex_funct3;
   logic [6:0]        ex_funct7;
   logic              stall_id;
   logic [CNT_W-1:0]  bubble_count;

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_aluop(id_aluop),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7(id_funct7),
      .ex_hold(ex_hold), .flush(flush),
      .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_aluop(ex_aluop), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .stall_id(stall_id), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: what EX should hold, tracked as plain variables.
   bit              m_valid;
   bit [6:0]        m_ctrl;   // {alusrc,memtoreg,regwrite,memread,memwrite,aluop}
   bit [DATA_W-1:0] m_rs1d, m_rs2d, m_imm;
   bit [REG_W-1:0]  m_rs1, m_rs2, m_rd;
   bit [2:0]        m_f3;
   bit [6:0]        m_f7;
   int              m_cnt;

   function automatic bit model_hazard();
      bit reads_rd;
      bit ex_is_load;
      ex_is_load = m_valid && m_ctrl[3] && (m_rd != 0);
      reads_rd   = (id_rs1 == m_rd) ||
                   ((!id_alusrc || id_memwrite) && (id_rs2 == m_rd));
      return ex_is_load && id_valid && reads_rd;
   endfunction

   task automatic tick();
      bit hz;
      #1;
      hz = model_hazard();
      chk("stall_id", 64'(stall_id), 64'(hz || ex_hold));
      if (!rst_n) begin
         m_valid = 0; m_ctrl = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
         m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_cnt = 0;
      end else if (flush) begin
         m_valid = 0; m_ctrl = 0;
      end else if (ex_hold) begin
         // nothing moves
      end else if (hz) begin
         m_valid = 0; m_ctrl = 0;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
         m_valid = id_valid;
         m_ctrl  = id_valid ? {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                               id_memwrite, id_aluop} : 7'd0;
         m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
         m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
         m_f3 = id_funct3; m_f7 = id_funct7;
      end
      @(posedge clk);
      #1;
      chk("ex_valid", 64'(ex_valid), 64'(m_valid));
      chk("ex_ctrl", 64'({ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_aluop}),
          64'(m_ctrl));
      chk("ex_data", {ex_rs1_data, ex_rs2_data}, {m_rs1d, m_rs2d});
      chk("ex_imm", 64'(ex_imm), 64'(m_imm));
      chk("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}),
          64'({m_rs1, m_rs2, m_rd, m_f3, m_f7}));
      chk("bubble_count", 64'(bubble_count), 64'(m_cnt));
   endtask

   task automatic set_instr(input bit v, input bit alusrc, input bit memtoreg, input bit regwrite,
                            input bit memread, input bit memwrite, input bit [1:0] aluop,
                            input int rs1, input int rs2, input int rd,
                            input int rs1d, input int rs2d, input int imm);
      id_valid = v; id_alusrc = alusrc; id_memtoreg = memtoreg; id_regwrite = regwrite;
      id_memread = memread; id_memwrite = memwrite; id_aluop = aluop;
      id_rs1 = REG_W'(rs1); id_rs2 = REG_W'(rs2); id_rd = REG_W'(rd);
      id_rs1_data = DATA_W'(rs1d); id_rs2_data = DATA_W'(rs2d); id_imm = DATA_W'(imm);
      id_funct3 = 3'(rd); id_funct7 = 7'(rs1 + rs2);
   endtask

   task automatic lw(input int rd, input int rs1);
      set_instr(1, 1, 1, 1, 1, 0, ALUOP_ADD, rs1, 0, rd, 100, 0, 8);
   endtask

   task automatic add(input int rd, input int rs1, input int rs2, input int a, input int b);
      set_instr(1, 0, 0, 1, 0, 0, ALUOP_FUNCT, rs1, rs2, rd, a, b, 0);
   endtask

   initial begin
      rst_n = 0; ex_hold = 0; flush = 0;
      set_instr(1, 1, 1, 1, 1, 1, 2'b11, $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(1, 31), $urandom, $urandom, $urandom);
      m_valid = 0; m_ctrl = 0; m_cnt = 0;
      tick();
      tick();
      chk("reset_stall", 64'(stall_id), 64'd0);
      rst_n = 1;

      add(3, 1, 2, 5, 7);
      tick();
      chk("add_aluop", 64'(ex_aluop), 64'd2);
      chk("add_rd", 64'(ex_rd), 64'd3);
      chk("add_ops", {ex_rs1_data, ex_rs2_data}, {32'd5, 32'd7});

      lw(5, 1);
      tick();
      add(6, 5, 1, 11, 12);
      #1 chk("loaduse_stall", 64'(stall_id), 64'd1);
      tick();
      chk("loaduse_bubble", 64'(ex_valid), 64'd0);
      chk("loaduse_count", 64'(bubble_count), 64'd1);
      tick();
      chk("loaduse_add_rd", 64'(ex_rd), 64'd6);

      lw(0, 1);
      tick();
      add(8, 0, 0, 1, 2);
      tick();
      lw(5, 2);
      tick();
      set_instr(1, 1, 0, 1, 0, 0, ALUOP_ADD, 1, 5, 7, 3, 4, 42);
      tick();
      chk("no_stall_count", 64'(bubble_count), 64'd1);

      lw(5, 1);
      tick();
      add(9, 5, 5, 1, 1);
      flush = 1;
      tick();
      flush = 0;
      chk("flush_valid", 64'(ex_valid), 64'd0);
      chk("flush_count", 64'(bubble_count), 64'd1);

      add(10, 3, 4, 20, 30);
      tick();
      add(11, 1, 2, 40, 50);
      ex_hold = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_rd", 64'(ex_rd), 64'd10);
      end
      ex_hold = 0;
      tick();
      chk("hold_release_rd", 64'(ex_rd), 64'd11);

      for (int i = 0; i < 5; i++) begin
         lw(5, 1);
         tick();
         add(12, 1, 5, i, i);
         tick();
         tick();
      end
      chk("sat_count", 64'(bubble_count), 64'(CNT_MAX));

      for (int i = 0; i < 3000; i++) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         flush   = ($urandom_range(0, 19) == 0);
         ex_hold = ($urandom_range(0, 9) == 0);
         set_instr($urandom_range(0, 5) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, $urandom, $urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
